// File: rtl/reorder_buffer_ex.sv
// reorder_buffer_ex: in-order retirement buffer that frees old physical tags
module reorder_buffer_ex #(
    parameter int ROB_SIZE     = 16,
    parameter int TAG_W        = 6,
    parameter int WAKEUP_PORTS = 4,
    parameter int RETIRE_WIDTH = 2,
    parameter int IDX_W        = $clog2(ROB_SIZE)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enqueue_enable,
    input  logic [TAG_W-1:0]              enqueue_old_tag,
    output logic                          enqueue_ready,
    output logic [IDX_W-1:0]              next_rob_index,
    input  logic [WAKEUP_PORTS-1:0]       wakeup_active,
    input  logic [WAKEUP_PORTS*IDX_W-1:0] wakeup_rob_index,
    input  logic                          flush,
    output logic [RETIRE_WIDTH-1:0]       freed_valid,
    output logic [RETIRE_WIDTH*TAG_W-1:0] freed_tags,
    output logic [IDX_W:0]                count,
    output logic                          empty
);
    logic [ROB_SIZE-1:0]             occupied, done, wake_hit, done_m, ret_clr, enq_set;
    logic [ROB_SIZE-1:0][TAG_W-1:0]  old_tag;
    logic [IDX_W-1:0]                head, tail, slot;
    logic [RETIRE_WIDTH-1:0]         ret_mask;
    logic [RETIRE_WIDTH*TAG_W-1:0]   ret_tags;
    logic [IDX_W:0]                  ret_n;
    logic                            enq_fire, run;

    // count never exceeds ROB_SIZE, so its top bit alone means full
    assign enqueue_ready  = !count[IDX_W];
    assign next_rob_index = tail;
    assign empty          = count == '0;
    assign enq_fire       = enqueue_enable && enqueue_ready;
    assign enq_set        = enq_fire ? (ROB_SIZE'(1) << tail) : '0;

    // merge this cycle's wakeups into done, ignoring unoccupied slots
    always_comb begin
        wake_hit = '0;
        for (int p = 0; p < WAKEUP_PORTS; p++)
            if (wakeup_active[p]) wake_hit[wakeup_rob_index[p*IDX_W +: IDX_W]] = 1'b1;
        done_m = done | (occupied & wake_hit);
    end

    // retire the run of done entries starting at head, up to RETIRE_WIDTH
    always_comb begin
        ret_mask = '0;
        ret_tags = '0;
        ret_clr  = '0;
        ret_n    = '0;
        run      = 1'b1;
        slot     = head;
        for (int k = 0; k < RETIRE_WIDTH; k++) begin
            slot = head + IDX_W'(k);
            run  = run && occupied[slot] && done_m[slot];
            if (run) begin
                ret_mask[k]                 = 1'b1;
                ret_tags[k*TAG_W +: TAG_W]  = old_tag[slot];
                ret_clr[slot]               = 1'b1;
                ret_n                       = ret_n + (IDX_W+1)'(1);
            end
        end
    end

    // state update; flush wins over retire, enqueue and wakeup
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occupied    <= '0;
            done        <= '0;
            old_tag     <= '0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            freed_valid <= '0;
            freed_tags  <= '0;
        end else if (flush) begin
            occupied    <= '0;
            done        <= '0;
            tail        <= head;
            count       <= '0;
            freed_valid <= '0;
            freed_tags  <= '0;
        end else begin
            occupied <= (occupied & ~ret_clr) | enq_set;
            done     <= done_m & ~ret_clr & ~enq_set;
            if (enq_fire) begin
                old_tag[tail] <= enqueue_old_tag;
                tail          <= tail + IDX_W'(1);
            end
            head        <= head + ret_n[IDX_W-1:0];
            count       <= count + (IDX_W+1)'(enq_fire) - ret_n;
            freed_valid <= ret_mask;
            freed_tags  <= ret_tags;
        end
    end
endmodule

// File: tb/tb_reorder_buffer_ex.sv
// tb_reorder_buffer_ex: directed + randomized check of reorder_buffer_ex against a queue model
module tb_reorder_buffer_ex;
    localparam int RS = 4;
    localparam int TW = 6;
    localparam int WP = 4;
    localparam int RW = 2;
    localparam int IW = 2;

    logic           clk = 0;
    logic           rst_n;
    logic           enqueue_enable;
    logic [TW-1:0]  enqueue_old_tag;
    logic           enqueue_ready;
    logic [IW-1:0]  next_rob_index;
    logic [WP-1:0]  wakeup_active;
    logic [WP*IW-1:0] wakeup_rob_index;
    logic           flush;
    logic [RW-1:0]  freed_valid;
    logic [RW*TW-1:0] freed_tags;
    logic [IW:0]    count;
    logic           empty;

    int total = 0;
    int bad = 0;
    bit chk_on = 0;

    // model: program-ordered queues of tags and done flags, plus head index
    logic [TW-1:0] tq[$];
    bit            dq[$];
    int            m_head = 0;
    logic [RW-1:0] m_fv = '0;
    logic [RW*TW-1:0] m_ft = '0;

    reorder_buffer_ex #(.ROB_SIZE(RS), .TAG_W(TW), .WAKEUP_PORTS(WP), .RETIRE_WIDTH(RW)) dut (
        .clk(clk), .rst_n(rst_n), .enqueue_enable(enqueue_enable), .enqueue_old_tag(enqueue_old_tag),
        .enqueue_ready(enqueue_ready), .next_rob_index(next_rob_index), .wakeup_active(wakeup_active),
        .wakeup_rob_index(wakeup_rob_index), .flush(flush), .freed_valid(freed_valid),
        .freed_tags(freed_tags), .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    initial forever begin
        int n_pre;
        int off;
        int k;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            tq.delete();
            dq.delete();
            m_head = 0;
            m_fv = '0;
            m_ft = '0;
        end else if (flush) begin
            tq.delete();
            dq.delete();
            m_fv = '0;
            m_ft = '0;
        end else begin
            n_pre = tq.size();
            for (int p = 0; p < WP; p++)
                if (wakeup_active[p]) begin
                    off = ((int'(wakeup_rob_index[p*IW +: IW]) - m_head) % RS + RS) % RS;
                    if (off < n_pre) dq[off] = 1'b1;
                end
            m_fv = '0;
            m_ft = '0;
            k = 0;
            while (k < RW && tq.size() > 0 && dq[0]) begin
                m_fv[k] = 1'b1;
                m_ft[k*TW +: TW] = tq[0];
                void'(tq.pop_front());
                void'(dq.pop_front());
                m_head = (m_head + 1) % RS;
                k++;
            end
            if (enqueue_enable && n_pre < RS) begin
                tq.push_back(enqueue_old_tag);
                dq.push_back(1'b0);
            end
        end
    end

    always @(negedge clk) if (chk_on) begin
        chk("m_count", 32'(count), 32'(tq.size()));
        chk("m_empty", 32'(empty), 32'(tq.size() == 0));
        chk("m_ready", 32'(enqueue_ready), 32'(tq.size() < RS));
        chk("m_next", 32'(next_rob_index), 32'((m_head + tq.size()) % RS));
        chk("m_fvalid", 32'(freed_valid), 32'(m_fv));
        chk("m_ftags", 32'(freed_tags), 32'(m_ft));
    end

    task automatic clr();
        enqueue_enable = 0;
        enqueue_old_tag = '0;
        wakeup_active = '0;
        wakeup_rob_index = '0;
        flush = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        clr();
    endtask

    task automatic enq(input int t);
        enqueue_enable = 1;
        enqueue_old_tag = TW'(t);
    endtask

    task automatic wake(input int p, input int idx);
        logic [IW-1:0] i2;
        i2 = IW'(idx);
        wakeup_active[p] = 1'b1;
        wakeup_rob_index[p*IW +: IW] = i2;
    endtask

    initial begin
        rst_n = 0;
        clr();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        chk_on = 1;
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_ready", 32'(enqueue_ready), 1);
        chk("rst_next", 32'(next_rob_index), 0);
        chk("rst_fvalid", 32'(freed_valid), 0);
        for (int t = 1; t <= 4; t++) begin
            chk("enq_idx", 32'(next_rob_index), 32'(t - 1));
            enq(t);
            step();
        end
        chk("full_count", 32'(count), 4);
        chk("full_ready", 32'(enqueue_ready), 0);
        enq(9);
        step();
        chk("drop_count", 32'(count), 4);
        chk("drop_next", 32'(next_rob_index), 0);
        wake(0, 1);
        step();
        chk("w1_fvalid", 32'(freed_valid), 0);
        wake(1, 2);
        step();
        chk("w2_fvalid", 32'(freed_valid), 0);
        wake(2, 0);
        step();
        chk("w0_fvalid", 32'(freed_valid), 3);
        chk("w0_ftags", 32'(freed_tags), 32'h081);
        step();
        chk("r3_fvalid", 32'(freed_valid), 1);
        chk("r3_ftags", 32'(freed_tags), 3);
        step();
        chk("idle_fvalid", 32'(freed_valid), 0);
        wake(0, 3);
        step();
        chk("w3_fvalid", 32'(freed_valid), 1);
        chk("w3_ftags", 32'(freed_tags), 4);
        chk("w3_empty", 32'(empty), 1);
        for (int t = 11; t <= 14; t++) begin
            enq(t);
            step();
        end
        wake(0, 0);
        enq(15);
        step();
        chk("fr_fvalid", 32'(freed_valid), 1);
        chk("fr_ftags", 32'(freed_tags), 11);
        chk("fr_count", 32'(count), 3);
        chk("fr_next", 32'(next_rob_index), 0);
        wake(0, 2);
        wake(3, 3);
        step();
        chk("pre_fl_fvalid", 32'(freed_valid), 0);
        flush = 1;
        wake(1, 1);
        step();
        chk("fl_fvalid", 32'(freed_valid), 0);
        chk("fl_count", 32'(count), 0);
        chk("fl_next", 32'(next_rob_index), 1);
        enq(20);
        step();
        chk("postfl_count", 32'(count), 1);
        chk("postfl_next", 32'(next_rob_index), 2);
        enq(21);
        wake(0, 2);
        step();
        chk("sw_count", 32'(count), 2);
        chk("sw_fvalid", 32'(freed_valid), 0);
        step();
        chk("sw_idle_fvalid", 32'(freed_valid), 0);
        wake(0, 1);
        step();
        chk("sw_h_fvalid", 32'(freed_valid), 1);
        chk("sw_h_ftags", 32'(freed_tags), 20);
        wake(1, 2);
        step();
        chk("sw_t_fvalid", 32'(freed_valid), 1);
        chk("sw_t_ftags", 32'(freed_tags), 21);
        rst_n = 0;
        step();
        rst_n = 1;
        for (int i = 0; i < 6; i++) begin
            chk("wrap_idx", 32'(next_rob_index), 32'(i % 4));
            enq(30 + i);
            step();
            wake(0, i % 4);
            step();
            chk("wrap_fvalid", 32'(freed_valid), 1);
            chk("wrap_ftags", 32'(freed_tags), 32'(30 + i));
        end
        chk("wrap_next", 32'(next_rob_index), 2);
        enq(40);
        step();
        enq(41);
        wake(0, 2);
        step();
        chk("prerst_ftags", 32'(freed_tags), 40);
        #2;
        rst_n = 0;
        #1;
        chk("ar_count", 32'(count), 0);
        chk("ar_empty", 32'(empty), 1);
        chk("ar_ready", 32'(enqueue_ready), 1);
        chk("ar_next", 32'(next_rob_index), 0);
        chk("ar_fvalid", 32'(freed_valid), 0);
        chk("ar_ftags", 32'(freed_tags), 0);
        @(posedge clk);
        #1;
        rst_n = 1;
        enq(42);
        step();
        chk("post_rst_next", 32'(next_rob_index), 1);
        chk("post_rst_count", 32'(count), 1);
        for (int c = 0; c < 300; c++) begin
            enqueue_enable = 1'($urandom_range(0, 1));
            enqueue_old_tag = TW'($urandom);
            wakeup_active = WP'($urandom);
            wakeup_rob_index = (WP*IW)'($urandom);
            flush = ($urandom_range(0, 31) == 0);
            step();
        end
        step();
        chk_on = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/reorder_buffer_ex.md
REORDER_BUFFER_EX -- requirements
Module: reorder_buffer_ex

Interface
REQ-001 SHALL have parameter ROB_SIZE, default 16, entry count; power of two, >= 4.
REQ-002 SHALL have parameter TAG_W, default 6, physical-tag width; tag 0 means "no tag".
REQ-003 SHALL have parameter WAKEUP_PORTS, default 4, number of completion ports.
REQ-004 SHALL have parameter RETIRE_WIDTH, default 2, maximum retirements per cycle; range 1..ROB_SIZE.
REQ-005 SHALL derive IDX_W = log2(ROB_SIZE).
REQ-006 clk  in  1  sole clock; all state changes on its rising edge.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 enqueue_enable  in  1  request to allocate one entry this cycle.
REQ-009 enqueue_old_tag  in  TAG_W  tag to free when the new entry retires.
REQ-010 enqueue_ready  out  1  high when count < ROB_SIZE.
REQ-011 next_rob_index  out  IDX_W  index the next enqueue receives (tail pointer).
REQ-012 wakeup_active  in  WAKEUP_PORTS  per-port completion valid.
REQ-013 wakeup_rob_index  in  WAKEUP_PORTS*IDX_W  per-port completed index; port p at bits [p*IDX_W +: IDX_W].
REQ-014 flush  in  1  discard all un-retired entries.
REQ-015 freed_valid  out  RETIRE_WIDTH  per-slot retirement valid.
REQ-016 freed_tags  out  RETIRE_WIDTH*TAG_W  per-slot freed old tag; slot k at bits [k*TAG_W +: TAG_W].
REQ-017 count  out  IDX_W+1  occupied entries.
REQ-018 empty  out  1  high when count == 0.

Function
REQ-019 SHALL be a circular buffer: head (oldest), tail, count; each entry holds occupied, done, old_tag; pointers wrap modulo ROB_SIZE.
REQ-020 SHALL accept an enqueue only when enqueue_enable && enqueue_ready; writes entry at tail (occupied=1, done=0), tail+1; enqueue while full is dropped, state unchanged.
REQ-021 enqueue_ready SHALL use pre-edge count only; a same-edge retirement does not free space for that edge's enqueue.
REQ-022 SHALL set done on every occupied entry named by an active wakeup port; wakeups to unoccupied indices, including the index enqueued on the same edge, SHALL be ignored; duplicate-port hits are harmless.
REQ-023 Retirement SHALL use done bits merged with same-cycle wakeups: at each edge retire the longest run of consecutive done entries from head, capped at RETIRE_WIDTH; stop at the first not-done entry.
REQ-024 freed_valid/freed_tags SHALL be registered, valid for exactly one cycle after the retiring edge; slot 0 oldest, filled contiguously; unused slots valid=0, tag=0.
REQ-025 Retired entries SHALL be cleared (occupied=0, done=0); head advances by the retire count; count += enqueued - retired.
REQ-026 A retired old_tag of 0 SHALL still assert freed_valid with tag 0.
REQ-027 flush SHALL have priority: at that edge, no retirement, enqueue, or wakeup takes effect; all entries are cleared; tail=head; count=0; freed_valid=0.
REQ-028 next_rob_index, enqueue_ready, count, empty SHALL be driven from registered state only.

Reset
REQ-029 rst_n low SHALL immediately force head=tail=0, count=0, all entries cleared, freed_valid=0, freed_tags=0, next_rob_index=0, enqueue_ready=1, empty=1, independent of clk.
REQ-030 Reset asserted mid-operation SHALL discard all entries with no freed output; first edge after release behaves as from empty.

Verification
REQ-031 ROB_SIZE=4, RETIRE_WIDTH=2: enqueue tags 1..4 -> indices 0,1,2,3 distinct; then enqueue_ready=0, count=4; fifth enqueue dropped.
REQ-032 Wake idx1, then idx2 -> no freed_valid; wake idx0 -> next cycle freed_valid=2'b11, tags 1,2; following cycle slot0 tag 3 only; later wake idx3 -> slot0 tag 4; empty=1.
REQ-033 Full ROB, head done, enqueue same edge -> one retirement, enqueue dropped, count=3, next_rob_index unchanged.
REQ-034 Three entries, wake idx1 and idx2 on separate ports same cycle, then flush with wakeup of idx0 -> freed_valid=0, count=0, next_rob_index=head; subsequent enqueue lands at the old head.
REQ-035 Enqueue and wakeup of next_rob_index same edge -> entry stays not-done; no retirement until a later wakeup.
REQ-036 Tail wrap: after 6 enqueue/retire pairs with ROB_SIZE=4, next_rob_index=2 and freed tags keep program order; rst_n pulse mid-run -> all outputs zero, enqueue_ready=1.
